pipe_trace_buf: RTL
===================

PIPE_TRACE_BUF -- requirements
Module: pipe_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH).
REQ-003 SHALL have parameter NSTAGE, default 5, meaning pipeline stages observed.
REQ-004 SHALL have parameter POST, default 4, meaning entries captured after a trigger match.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cap_en  input  1  capture enable for this cycle.
REQ-008 SHALL have port mode  input  2  00 wrap, 01 stop-on-full, 10 trigger, 11 treated as 00.
REQ-009 SHALL have port clr  input  1  synchronous clear of pointers, count and flags.
REQ-010 SHALL have port pc  input  32  fetch PC.
REQ-011 SHALL have port stage_instr  input  NSTAGE*32  stage instructions; stage k in bits [32k+31:32k], IF = stage 0.
REQ-012 SHALL have port stage_sel  input  3  stage captured; values >= NSTAGE capture 32'h0.
REQ-013 SHALL have port trig_pc  input  32  trigger PC for mode 10.
REQ-014 SHALL have port rd_req  input  1  read request.
REQ-015 SHALL have port rd_idx  input  AW  entry index, 0 = oldest.
REQ-016 SHALL have port rd_vld  output  1  read data valid.
REQ-017 SHALL have ports rd_pc / rd_instr  output  32 each  read entry.
REQ-018 SHALL have port count  output  AW+1  valid entries, 0..DEPTH.
REQ-019 SHALL have ports full, wrapped, triggered, done  output  1 each  status flags.

Function
REQ-020 Write SHALL occur on a rising edge iff cap_en=1, done=0 and clr=0; entry = {pc, selected stage_instr} at wr_ptr.
REQ-021 wr_ptr SHALL increment by 1 per write, wrapping DEPTH-1 -> 0.
REQ-022 count SHALL increment per write, saturating at DEPTH; full = (count==DEPTH), combinational from count.
REQ-023 Modes 00/11: a write with count==DEPTH SHALL overwrite the oldest entry and set wrapped (sticky).
REQ-024 Mode 01: done SHALL set on the write that makes count==DEPTH; later writes ignored, no overwrite.
REQ-025 Mode 10: wrap as mode 00 until trigger; the first write with pc==trig_pc SHALL set triggered (sticky) and load post counter with POST.
REQ-026 Mode 10: each later write SHALL decrement post counter; done SHALL set on the write taking it to 0 (match entry + POST entries captured); POST=0 sets done on the match write.
REQ-027 Further pc==trig_pc matches after triggered=1 SHALL NOT reload the post counter.
REQ-028 Read: rd_req sampled at edge N; at edge N+1 rd_vld=1 for one cycle with entry at (wr_ptr - count + rd_idx) mod DEPTH, using pointer state before any write at edge N.
REQ-029 rd_idx >= count SHALL return rd_vld=1 with rd_pc=rd_instr=0.
REQ-030 Back-to-back rd_req SHALL give one result per cycle, latency 1; no rd_req -> rd_vld=0.
REQ-031 clr SHALL zero wr_ptr, count, post counter, wrapped, triggered, done and rd_vld next edge; memory contents unchanged; clr has priority over write.
REQ-032 Mode change SHALL take effect at the next edge; done only cleared by clr or rst.

Reset
REQ-033 rst=0 SHALL immediately clear wr_ptr, count, post counter, all flags, rd_vld, rd_pc, rd_instr; memory need not reset.
REQ-034 Reset asserted mid-capture or mid-read SHALL discard the in-flight read; first write after release goes to entry 0.

Verification
REQ-035 Mode 00, DEPTH=16, 20 writes pc=0x00..0x4C step 4 -> count=16, wrapped=1, rd_idx=0 returns pc=0x10, rd_idx=15 pc=0x4C.
REQ-036 Mode 01, 20 writes -> done=1 after 16th, rd_idx=15 returns pc=0x3C, count stays 16.
REQ-037 Mode 10, POST=4, trig_pc=0x20, pc stepping 4 from 0 -> triggered on pc=0x20, done after pc=0x30, newest entry pc=0x30.
REQ-038 stage_sel=2 with stage 2 instr 0x8C010004 -> captured rd_instr=0x8C010004; stage_sel=7 -> 0.
REQ-039 Simultaneous rd_req (idx 0) and write at count=3 -> read returns pre-write oldest entry, count becomes 4.
REQ-040 rst low mid mode-10 capture -> all outputs 0 at once; clr after done -> done=0, count=0, capture resumes.

Source files
------------

// File: rtl/pipe_trace_buf.sv
// Pipeline trace buffer: records {pc, stage instruction} per enabled cycle.
// Wrap, stop-on-full and PC-trigger capture modes with an indexed read port.
module pipe_trace_buf #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int NSTAGE = 5,
    parameter int POST   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic [1:0]             mode,
    input  logic                   clr,
    input  logic [31:0]            pc,
    input  logic [NSTAGE*32-1:0]   stage_instr,
    input  logic [2:0]             stage_sel,
    input  logic [31:0]            trig_pc,
    input  logic                   rd_req,
    input  logic [AW-1:0]          rd_idx,
    output logic                   rd_vld,
    output logic [31:0]            rd_pc,
    output logic [31:0]            rd_instr,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   wrapped,
    output logic                   triggered,
    output logic                   done
);

    localparam int PW = (POST < 2) ? 1 : $clog2(POST + 1);
    localparam logic [AW:0] CMAX = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] PLOAD = PW'(POST);

    logic [31:0]   mem_pc  [DEPTH];
    logic [31:0]   mem_ins [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [PW-1:0] post_cnt;
    logic [31:0]   sel_instr;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;
    logic          is_stop;
    logic          is_trig;
    logic          wr_en;

    assign is_stop = (mode == 2'b01);
    assign is_trig = (mode == 2'b10);
    assign full    = (count == CMAX);
    // In stop mode a full buffer is never overwritten, even if done is clear.
    assign wr_en   = cap_en & ~done & ~clr & ~(is_stop & full);
    assign rd_addr = wr_ptr - count[AW-1:0] + rd_idx;
    assign rd_hit  = ({1'b0, rd_idx} < count);

    // Select the observed stage; out-of-range selects give zero.
    always_comb begin
        sel_instr = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (stage_sel == 3'(k)) sel_instr = stage_instr[32*k +: 32];
        end
    end

    // Trace storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]  <= pc;
            mem_ins[wr_ptr] <= sel_instr;
        end
    end

    // Pointer, occupancy, trigger and status flag state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full) wrapped <= 1'b1;
            else      count   <= count + 1'b1;
            if (is_stop && count == CMAX - 1'b1) done <= 1'b1;
            if (is_trig) begin
                if (!triggered && pc == trig_pc) begin
                    triggered <= 1'b1;
                    post_cnt  <= PLOAD;
                    if (POST == 0) done <= 1'b1;
                end else if (triggered && post_cnt != '0) begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == PW'(1)) done <= 1'b1;
                end
            end
        end
    end

    // Registered read port: one result per request, pre-write pointer view.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld   <= 1'b0;
            rd_pc    <= '0;
            rd_instr <= '0;
        end else if (clr) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_pc    <= rd_hit ? mem_pc[rd_addr]  : 32'h0;
                rd_instr <= rd_hit ? mem_ins[rd_addr] : 32'h0;
            end
        end
    end

endmodule
